// File: rtl/leve1_csr_exec_if.sv
// ---------------------------------------------------------------------------
// leve1_csr_exec_if
// Bundle between the Zicsr execute stage, its upstream decoder, the CSR
// register file and writeback.
//
// Signal groups (XLEN = data width, 64 by default):
//   request   : REQ_VALID, REQ_READY, REQ_OP[2:0], REQ_CSR[11:0],
//               REQ_RS1_DATA[XLEN], REQ_RS1[4:0], REQ_RD[4:0], REQ_MODE[1:0]
//   CSR read  : CSR_RA[11:0] -> CSR_RDATA[XLEN] (registered, one cycle later)
//   CSR write : CSR_WCMD[1:0], CSR_WA[11:0], CSR_WD[XLEN]
//   writeback : WB_VALID, WB_RD[4:0], WB_DATA[XLEN], WB_ILLEGAL, RETIRE
//
// Modports:
//   slave  - the execute stage itself
//   master - the environment (decoder, CSR file, writeback)
// ---------------------------------------------------------------------------
interface leve1_csr_exec_if #(
  parameter int XLEN = 64
);
  logic            REQ_VALID;
  logic            REQ_READY;
  logic [2:0]      REQ_OP;
  logic [11:0]     REQ_CSR;
  logic [XLEN-1:0] REQ_RS1_DATA;
  logic [4:0]      REQ_RS1;
  logic [4:0]      REQ_RD;
  logic [1:0]      REQ_MODE;

  logic [11:0]     CSR_RA;
  logic [XLEN-1:0] CSR_RDATA;
  logic [1:0]      CSR_WCMD;
  logic [11:0]     CSR_WA;
  logic [XLEN-1:0] CSR_WD;

  logic            WB_VALID;
  logic [4:0]      WB_RD;
  logic [XLEN-1:0] WB_DATA;
  logic            WB_ILLEGAL;
  logic            RETIRE;

  modport slave (
    input  REQ_VALID, REQ_OP, REQ_CSR, REQ_RS1_DATA, REQ_RS1, REQ_RD, REQ_MODE,
    input  CSR_RDATA,
    output REQ_READY,
    output CSR_RA, CSR_WCMD, CSR_WA, CSR_WD,
    output WB_VALID, WB_RD, WB_DATA, WB_ILLEGAL, RETIRE
  );

  modport master (
    output REQ_VALID, REQ_OP, REQ_CSR, REQ_RS1_DATA, REQ_RS1, REQ_RD, REQ_MODE,
    output CSR_RDATA,
    input  REQ_READY,
    input  CSR_RA, CSR_WCMD, CSR_WA, CSR_WD,
    input  WB_VALID, WB_RD, WB_DATA, WB_ILLEGAL, RETIRE
  );
endinterface

// File: rtl/leve1_csr_exec.sv
// ---------------------------------------------------------------------------
// leve1_csr_exec
// Execute stage for Zicsr instructions (CSRRW/RS/RC and the immediate forms).
// One op is accepted in IDLE, the old CSR value is read in RD (the CSR file
// answers one cycle later), and in EX the merged value is written back to the
// CSR file while the old value goes to writeback. One op per three cycles.
//
// Ports:
//   CLK  - clock, all flops on posedge
//   RST  - asynchronous, active-high reset
//   bus  - leve1_csr_exec_if.slave (request, CSR read/write, writeback)
//
// Configuration:
//   LEVE1_CSR_EXEC_PRIV_CHECK_EN - when defined, an op whose captured privilege
//   mode is below the CSR's minimum privilege (csr[9:8]) is illegal, reads
//   included. Undefined: the mode is captured but not used.
// ---------------------------------------------------------------------------
module leve1_csr_exec #(
  parameter int XLEN = 64
) (
  input  logic              CLK,
  input  logic              RST,
  leve1_csr_exec_if.slave   bus
);

  localparam logic [1:0] CSR_NONE  = 2'b00;
  localparam logic [1:0] CSR_WRITE = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EX   = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]      op;
    logic [11:0]     csr;
    logic [XLEN-1:0] rs1data;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [1:0]      mode;
  } op_t;

  state_e state_q, state_d;
  op_t    op_q, op_d;

  // ---------------------------------------------------------------------------
  // State and captured op
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (bus.REQ_VALID) begin
          op_d.op      = bus.REQ_OP;
          op_d.csr     = bus.REQ_CSR;
          op_d.rs1data = bus.REQ_RS1_DATA;
          op_d.rs1     = bus.REQ_RS1;
          op_d.rd      = bus.REQ_RD;
          op_d.mode    = bus.REQ_MODE;
          state_d      = RD;
        end
      end
      RD:      state_d = EX;
      EX:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand select, merge, legality
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] merged;
  logic            legal_op;
  logic            do_wr;
  logic            priv_fail;
  logic            illegal;

`ifdef LEVE1_CSR_EXEC_PRIV_CHECK_EN
  assign priv_fail = (op_q.mode < op_q.csr[9:8]);
`else
  logic unused_mode;
  assign unused_mode = ^op_q.mode;
  assign priv_fail   = 1'b0;
`endif

  always_comb begin
    // funct3[2] selects the 5-bit zimm, always zero-extended to XLEN.
    src     = op_q.op[2] ? {{(XLEN-5){1'b0}}, op_q.rs1} : op_q.rs1data;
    old_val = bus.CSR_RDATA;
    case (op_q.op[1:0])
      2'b01:   merged = src;
      2'b10:   merged = old_val | src;
      2'b11:   merged = old_val & ~src;
      default: merged = '0;
    endcase
    // funct3 low bits 00 covers both reserved encodings 000 and 100.
    legal_op = (op_q.op[1:0] != 2'b00);
    // Set/clear with x0 / zimm 0 is a pure read and must not write.
    do_wr    = (op_q.op[1:0] == 2'b01) || (op_q.rs1 != 5'd0);
    illegal  = !legal_op || (do_wr && (op_q.csr[11:10] == 2'b11)) || priv_fail;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.REQ_READY  = (state_q == IDLE) && !RST;
    bus.CSR_RA     = op_q.csr;
    bus.CSR_WA     = op_q.csr;
    bus.CSR_WD     = merged;
    bus.WB_RD      = op_q.rd;
    bus.CSR_WCMD   = CSR_NONE;
    bus.WB_VALID   = 1'b0;
    bus.WB_ILLEGAL = 1'b0;
    bus.WB_DATA    = '0;
    bus.RETIRE     = 1'b0;
    if (state_q == EX) begin
      bus.WB_VALID   = 1'b1;
      bus.WB_ILLEGAL = illegal;
      if (!illegal) begin
        bus.WB_DATA  = old_val;
        bus.RETIRE   = 1'b1;
        bus.CSR_WCMD = do_wr ? CSR_WRITE : CSR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_leve1_csr_exec.sv
// ---------------------------------------------------------------------------
// tb_leve1_csr_exec
// Directed bench for leve1_csr_exec. A small CSR file model answers reads one
// cycle after CSR_RA and performs writes on CSR_WCMD==01. Inputs are driven
// and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_leve1_csr_exec;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  leve1_csr_exec_if #(.XLEN(XLEN)) bus ();

  leve1_csr_exec #(.XLEN(XLEN)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // CSR file model with a preload port
  logic [XLEN-1:0] csr_mem [0:4095];
  logic            pre_we   = 1'b0;
  logic [11:0]     pre_addr = '0;
  logic [XLEN-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) csr_mem[pre_addr] <= pre_data;
    else if (bus.CSR_WCMD == 2'b01) csr_mem[bus.CSR_WA] <= bus.CSR_WD;
    bus.CSR_RDATA <= csr_mem[bus.CSR_RA];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [63:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge where READY is seen.
  task automatic wait_ready();
    int i;
    for (i = 0; i < 20; i++) begin
      if (bus.REQ_READY) break;
      @(negedge clk);
    end
    if (i == 20) check("ready_timeout", 64'd0, 64'd1);
  endtask

  // Values captured from one op
  logic        rd_valid;
  logic        ex_valid, ex_ill, ex_retire;
  logic [1:0]  ex_wcmd;
  logic [11:0] ex_wa;
  logic [4:0]  ex_rd;
  logic [63:0] ex_wd, ex_data;

  task automatic drive(input logic [2:0] op, input logic [11:0] csr, input logic [63:0] d,
                       input logic [4:0] rs1, input logic [4:0] rd, input logic [1:0] mode);
    bus.REQ_OP = op; bus.REQ_CSR = csr; bus.REQ_RS1_DATA = d;
    bus.REQ_RS1 = rs1; bus.REQ_RD = rd; bus.REQ_MODE = mode;
    bus.REQ_VALID = 1'b1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [11:0] csr, input logic [63:0] d,
                       input logic [4:0] rs1, input logic [4:0] rd, input logic [1:0] mode);
    @(negedge clk);
    drive(op, csr, d, rs1, rd, mode);
    wait_ready();
    @(negedge clk);                 // RD
    bus.REQ_VALID = 1'b0;
    rd_valid = bus.WB_VALID;
    @(negedge clk);                 // EX
    ex_valid  = bus.WB_VALID;   ex_ill  = bus.WB_ILLEGAL; ex_retire = bus.RETIRE;
    ex_wcmd   = bus.CSR_WCMD;   ex_wa   = bus.CSR_WA;     ex_wd     = bus.CSR_WD;
    ex_rd     = bus.WB_RD;      ex_data = bus.WB_DATA;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int  k;
    logic saw, b2b_wr;
    bus.REQ_VALID = 1'b0; bus.REQ_OP = '0; bus.REQ_CSR = '0; bus.REQ_RS1_DATA = '0;
    bus.REQ_RS1 = '0; bus.REQ_RD = '0; bus.REQ_MODE = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",  bus.REQ_READY, 0);
    check("rst_wbv",    bus.WB_VALID, 0);
    check("rst_wcmd",   bus.CSR_WCMD, 0);
    check("rst_ra",     bus.CSR_RA, 0);
    check("rst_wa",     bus.CSR_WA, 0);
    check("rst_wd",     bus.CSR_WD, 0);
    check("rst_retire", bus.RETIRE, 0);
    check("rst_wbdata", bus.WB_DATA, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.REQ_READY, 1);

    preload(12'h340, 64'h1234);
    preload(12'h300, 64'h88);
    preload(12'hC00, 64'h777);

    // CSRRW 0x340 <- DEADBEEF, rd=5
    do_op(3'b001, 12'h340, 64'hDEAD_BEEF, 5'd7, 5'd5, 2'd3);
    check("rw_rd_wbv",  rd_valid, 0);
    check("rw_wbv",     ex_valid, 1);
    check("rw_wcmd",    ex_wcmd, 2'b01);
    check("rw_wa",      ex_wa, 12'h340);
    check("rw_wd",      ex_wd, 64'hDEAD_BEEF);
    check("rw_data",    ex_data, 64'h1234);
    check("rw_rd",      ex_rd, 5'd5);
    check("rw_ill",     ex_ill, 0);
    check("rw_retire",  ex_retire, 1);
    @(negedge clk);
    check("rw_mem",     csr_mem[12'h340], 64'hDEAD_BEEF);

    // CSRRS 0x300, rs1=x0: read only
    do_op(3'b010, 12'h300, 64'hFFFF, 5'd0, 5'd6, 2'd3);
    check("rs0_wcmd",   ex_wcmd, 2'b00);
    check("rs0_data",   ex_data, 64'h88);
    check("rs0_retire", ex_retire, 1);

    // CSRRCI 0x300, zimm=8: 0x88 -> 0x80
    do_op(3'b111, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 5'h08, 5'd6, 2'd3);
    check("rci_wcmd",   ex_wcmd, 2'b01);
    check("rci_wd",     ex_wd, 64'h80);
    check("rci_data",   ex_data, 64'h88);

    // CSRRSI 0x300, zimm=0x1F: zero-extended, rs1data ignored
    do_op(3'b110, 12'h300, 64'hFFFF_0000_0000_0000, 5'h1F, 5'd6, 2'd3);
    check("rsi_wd",     ex_wd, 64'h9F);
    check("rsi_data",   ex_data, 64'h80);

    // CSRRW to read-only 0xC00: illegal
    do_op(3'b001, 12'hC00, 64'h1, 5'd1, 5'd8, 2'd3);
    check("ro_wbv",     ex_valid, 1);
    check("ro_ill",     ex_ill, 1);
    check("ro_data",    ex_data, 0);
    check("ro_wcmd",    ex_wcmd, 2'b00);
    check("ro_retire",  ex_retire, 0);
    @(negedge clk);
    check("ro_mem",     csr_mem[12'hC00], 64'h777);

    // CSRRS 0xC00, rs1=x0: legal read
    do_op(3'b010, 12'hC00, 64'h1, 5'd0, 5'd8, 2'd3);
    check("ro_rd_ill",  ex_ill, 0);
    check("ro_rd_data", ex_data, 64'h777);

    // Reserved funct3 encodings
    do_op(3'b000, 12'h340, 64'h1, 5'd1, 5'd9, 2'd3);
    check("op000_ill",  ex_ill, 1);
    check("op000_data", ex_data, 0);
    check("op000_wcmd", ex_wcmd, 2'b00);
    do_op(3'b100, 12'h340, 64'h1, 5'd1, 5'd9, 2'd3);
    check("op100_ill",  ex_ill, 1);

    // rd = x0 still writes back and writes the CSR
    do_op(3'b001, 12'h305, 64'hAB, 5'd3, 5'd0, 2'd3);
    check("rd0_wbv",    ex_valid, 1);
    check("rd0_wcmd",   ex_wcmd, 2'b01);
    @(negedge clk);
    check("rd0_mem",    csr_mem[12'h305], 64'hAB);

    // Privilege: U-mode read of an M-level CSR (0x300 now holds 0x9F)
    do_op(3'b010, 12'h300, 64'h0, 5'd0, 5'd4, 2'd0);
`ifdef LEVE1_CSR_EXEC_PRIV_CHECK_EN
    check("privU_ill",  ex_ill, 1);
    check("privU_data", ex_data, 0);
`else
    check("privU_ill",  ex_ill, 0);
    check("privU_data", ex_data, 64'h9F);
`endif
    do_op(3'b010, 12'h300, 64'h0, 5'd0, 5'd4, 2'd3);
    check("privM_ill",  ex_ill, 0);
    check("privM_data", ex_data, 64'h9F);

    // Back-to-back: CSRRW 0x340 <- 0x55, then CSRRS 0x340 x0 held valid
    @(negedge clk);
    drive(3'b001, 12'h340, 64'h55, 5'd2, 5'd1, 2'd3);
    wait_ready();
    @(negedge clk);                 // RD of first op
    drive(3'b010, 12'h340, 64'h0, 5'd0, 5'd2, 2'd3);
    k = 1; b2b_wr = 1'b0;
    while (!bus.REQ_READY && k < 10) begin
      @(negedge clk);
      k++;
      if (bus.CSR_WCMD == 2'b01 && bus.CSR_WD == 64'h55) b2b_wr = 1'b1;
    end
    check("b2b_gap",    k, 3);
    check("b2b_wr1",    b2b_wr, 1);
    @(negedge clk);                 // RD of second op
    bus.REQ_VALID = 1'b0;
    @(negedge clk);                 // EX of second op
    check("b2b_data",   bus.WB_DATA, 64'h55);
    check("b2b_rd",     bus.WB_RD, 5'd2);
    check("b2b_wcmd",   bus.CSR_WCMD, 2'b00);

    // Reset pulse during RD of a CSRRW
    @(negedge clk);
    drive(3'b001, 12'h340, 64'h99, 5'd2, 5'd3, 2'd3);
    wait_ready();
    @(negedge clk);                 // RD
    bus.REQ_VALID = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", bus.REQ_READY, 0);
    check("midrst_wbv",   bus.WB_VALID, 0);
    check("midrst_wcmd",  bus.CSR_WCMD, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.WB_VALID || bus.CSR_WCMD != 2'b00) saw = 1'b1;
      if (i == 0) check("midrst_ready_after", bus.REQ_READY, 1);
    end
    check("midrst_no_pulse", saw, 0);
    check("midrst_mem",      csr_mem[12'h340], 64'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
